fta_ioslave32_regs: RTL and testbench



---
 rtl/fta_bus_pkg.sv | 45 ++++
 rtl/fta_bytelane_regs32.sv | 43 ++++
 rtl/fta_ioslave32_regs.sv | 138 +++++++++++++
 tb/tb_fta_ioslave32_regs.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fta_bus_pkg.sv
// Shared fta bus payload types and constants for 32-bit command-channel devices.
package fta_bus_pkg;

    localparam int unsigned FTA_TID_W = 8;
    localparam logic [3:0]  FTA_IO_DEFAULT_PRI = 4'd7;

    typedef logic [FTA_TID_W-1:0] fta_tid_t;

    typedef struct packed {
        logic        cyc;
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        fta_tid_t    tid;
    } fta_cmd_request32_t;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        rty;
        logic        stall;
        logic        next;
        logic [3:0]  pri;
        fta_tid_t    tid;
        logic [31:0] adr;
        logic [31:0] dat;
    } fta_cmd_response32_t;

    typedef enum logic [1:0] {
        IO_IDLE,
        IO_WAIT,
        IO_RESP
    } fta_io_state_e;

    // Zero every byte lane whose select bit is clear.
    function automatic logic [31:0] fta_lane_mask(input logic [31:0] d, input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[8*b +: 8] = sel[b] ? d[8*b +: 8] : 8'h00;
        end
        return m;
    endfunction

endpackage

// File: rtl/fta_bytelane_regs32.sv
// NREGS x 32-bit register bank with byte-lane writes, per-register write strobes
// and asynchronous clear.
module fta_bytelane_regs32 #(
    parameter int unsigned NREGS = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [$clog2(NREGS)-1:0]   idx_i,
    input  logic [3:0]                 sel_i,
    input  logic [31:0]                dat_i,
    output logic [32*NREGS-1:0]        q_o,
    output logic [NREGS-1:0]           wr_o
);

    logic [31:0]      regs_q [NREGS];
    logic [NREGS-1:0] wr_q;

    // The strobe fires on every accepted write, even with no lanes selected.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            regs_q <= '{default: '0};
            wr_q   <= '0;
        end else begin
            wr_q <= '0;
            if (we_i) begin
                wr_q[idx_i] <= 1'b1;
                for (int b = 0; b < 4; b++) begin
                    if (sel_i[b]) begin
                        regs_q[idx_i][8*b +: 8] <= dat_i[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NREGS); i++) begin : g_flat
        assign q_o[32*i +: 32] = regs_q[i];
    end

    assign wr_o = wr_q;

endmodule

// File: rtl/fta_ioslave32_regs.sv
// fta 32-bit register responder: window decode, wait-state FSM, byte-laned
// register access and ack/err response formatting.
module fta_ioslave32_regs
    import fta_bus_pkg::*;
#(
    parameter int unsigned NREGS       = 8,
    parameter logic [31:0] BASE        = 32'hFEE00000,
    parameter logic [31:0] MASK        = 32'hFFFFFF00,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [3:0]  PRI         = FTA_IO_DEFAULT_PRI
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  fta_cmd_request32_t    req,
    output fta_cmd_response32_t   resp,
    output logic [32*NREGS-1:0]   q_o,
    output logic [NREGS-1:0]      wr_o
);

    localparam int unsigned IDX_W  = $clog2({1'b0, ~MASK} + 33'd1) - 2;
    localparam int unsigned RIDX_W = $clog2(NREGS);
    localparam logic [3:0]  WS_MAX = 4'(WAIT_STATES);

    fta_io_state_e       state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                we_q, oor_q;
    logic [3:0]          sel_q;
    logic [31:0]         adr_q, dat_q;
    fta_tid_t            tid_q;
    fta_cmd_response32_t resp_q, resp_d;

    logic                cs_c, oor_c, is_idle_c, bank_we_c;
    logic [IDX_W-1:0]    idx_c;
    logic                t_we, t_oor;
    logic [3:0]          t_sel;
    logic [31:0]         t_adr, t_dat, rd_word_c;
    fta_tid_t            t_tid;
    logic [RIDX_W-1:0]   t_ridx;

    assign cs_c  = req.cyc & ((req.adr & MASK) == (BASE & MASK));
    assign idx_c = req.adr[2 +: IDX_W];
    assign oor_c = (32'(idx_c) >= NREGS);

    // With zero wait states the access completes straight from the live request.
    assign is_idle_c = (state_q == IO_IDLE);
    assign t_we   = is_idle_c ? req.we  : we_q;
    assign t_sel  = is_idle_c ? req.sel : sel_q;
    assign t_adr  = is_idle_c ? req.adr : adr_q;
    assign t_dat  = is_idle_c ? req.dat : dat_q;
    assign t_tid  = is_idle_c ? req.tid : tid_q;
    assign t_oor  = is_idle_c ? oor_c   : oor_q;
    assign t_ridx = t_adr[2 +: RIDX_W];
    assign rd_word_c = q_o[{t_ridx, 5'b0} +: 32];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IO_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IO_IDLE: if (cs_c) state_d = (WAIT_STATES == 0) ? IO_RESP : IO_WAIT;
            IO_WAIT: if (cnt_q >= WS_MAX) state_d = IO_RESP;
            IO_RESP: state_d = IO_IDLE;
            default: state_d = IO_IDLE;
        endcase
    end

    always_comb begin
        cnt_d       = '0;
        bank_we_c   = 1'b0;
        resp_d      = '0;
        resp_d.pri  = PRI;
        case (state_q)
            IO_IDLE: if (cs_c) cnt_d = 4'd1;
            IO_WAIT: if (cnt_q < WS_MAX) cnt_d = cnt_q + 4'd1;
            default: cnt_d = '0;
        endcase
        if (state_d == IO_RESP) begin
            resp_d.ack = ~t_oor;
            resp_d.err = t_oor;
            resp_d.tid = t_tid;
            resp_d.adr = t_adr;
            if (!t_we && !t_oor) begin
                resp_d.dat = fta_lane_mask(rd_word_c, t_sel);
            end
            bank_we_c = t_we & ~t_oor;
        end
    end

    // Request capture, wait counter and registered response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            we_q   <= 1'b0;
            oor_q  <= 1'b0;
            sel_q  <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
            tid_q  <= '0;
            resp_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            resp_q <= resp_d;
            if (is_idle_c && cs_c) begin
                we_q  <= req.we;
                oor_q <= oor_c;
                sel_q <= req.sel;
                adr_q <= req.adr;
                dat_q <= req.dat;
                tid_q <= req.tid;
            end
        end
    end

    always_comb begin
        resp       = resp_q;
        resp.stall = cs_c & ~is_idle_c;
    end

    fta_bytelane_regs32 #(
        .NREGS (NREGS)
    ) u_regs (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we_i  (bank_we_c),
        .idx_i (t_ridx),
        .sel_i (t_sel),
        .dat_i (t_dat),
        .q_o   (q_o),
        .wr_o  (wr_o)
    );

endmodule

// File: tb/tb_fta_ioslave32_regs.sv
// Self-checking bench for fta_ioslave32_regs: vector table through a response
// scoreboard, plus stall, miss, reset-abort and zero-wait-state sequences.
module tb_fta_ioslave32_regs;
    import fta_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fta_cmd_request32_t  req1, req0;
    fta_cmd_response32_t resp1, resp0;
    logic [255:0]        q1, q0;
    logic [7:0]          wr1, wr0;

    fta_ioslave32_regs #(.WAIT_STATES(1)) dut1 (
        .clk_i(clk), .rst_i(rst), .req(req1), .resp(resp1), .q_o(q1), .wr_o(wr1));
    fta_ioslave32_regs #(.WAIT_STATES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .req(req0), .resp(resp0), .q_o(q0), .wr_o(wr0));

    typedef struct {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [7:0]  tid;
        logic        ack;
        logic        err;
        logic [31:0] edat;
        logic [7:0]  ewr;
    } vec_t;

    typedef struct {
        int          cyc;
        logic        ack;
        logic        err;
        logic [7:0]  tid;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [7:0]  wr;
    } sb_t;

    sb_t         sbq[$];
    vec_t        vt[13];
    logic [31:0] mregs[8];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic        mon_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) mon_ok <= !rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor for the WAIT_STATES=1 instance.
    always @(negedge clk) begin
        if (!rst && mon_ok) begin
            if (resp1.ack || resp1.err) begin
                if (sbq.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL spurious_resp: got ack=%b err=%b tid=%h expected none (cycle %0d)",
                             resp1.ack, resp1.err, resp1.tid, cyc);
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    check("resp_cycle", 64'(cyc), 64'(e.cyc));
                    check("resp_ack_err", {62'b0, resp1.ack, resp1.err}, {62'b0, e.ack, e.err});
                    check("resp_tid", 64'(resp1.tid), 64'(e.tid));
                    check("resp_adr", 64'(resp1.adr), 64'(e.adr));
                    check("resp_dat", 64'(resp1.dat), 64'(e.dat));
                    check("resp_wr", 64'(wr1), 64'(e.wr));
                    check("resp_pri_rty_next", {58'b0, resp1.pri, resp1.rty, resp1.next}, {58'b0, 4'd7, 2'b00});
                end
            end else begin
                check("idle_adr_dat", {resp1.adr, resp1.dat}, 64'h0);
                check("idle_misc", {42'b0, resp1.rty, resp1.next, resp1.pri, resp1.tid, wr1},
                      {42'b0, 2'b00, 4'd7, 8'h00, 8'h00});
            end
        end
    end

    task automatic txn(input vec_t v);
        sb_t e;
        e.cyc = cyc + 2;
        e.ack = v.ack;
        e.err = v.err;
        e.tid = v.tid;
        e.adr = v.adr;
        e.dat = v.edat;
        e.wr  = v.ewr;
        sbq.push_back(e);
        req1 = '{cyc: 1'b1, we: v.we, sel: v.sel, adr: v.adr, dat: v.dat, tid: v.tid};
        step(1);
        req1 = '0;
        step(2);
        if (v.we && v.ack) begin
            for (int b = 0; b < 4; b++) begin
                if (v.sel[b]) mregs[v.adr[4:2]][8*b +: 8] = v.dat[8*b +: 8];
            end
        end
    endtask

    initial begin
        vt[0]  = '{1'b1, 4'hF, 32'hFEE00004, 32'h12345678, 8'h05, 1'b1, 1'b0, 32'h0,        8'h02};
        vt[1]  = '{1'b1, 4'h4, 32'hFEE00004, 32'hAABBCCDD, 8'h11, 1'b1, 1'b0, 32'h0,        8'h02};
        vt[2]  = '{1'b0, 4'hF, 32'hFEE00004, 32'h5A5A5A5A, 8'h12, 1'b1, 1'b0, 32'h12BB5678, 8'h00};
        vt[3]  = '{1'b0, 4'h3, 32'hFEE00004, 32'h0,        8'h13, 1'b1, 1'b0, 32'h00005678, 8'h00};
        vt[4]  = '{1'b0, 4'hF, 32'hFEE00020, 32'h0,        8'h14, 1'b0, 1'b1, 32'h0,        8'h00};
        vt[5]  = '{1'b1, 4'hF, 32'hFEE00020, 32'h99999999, 8'h15, 1'b0, 1'b1, 32'h0,        8'h00};
        vt[6]  = '{1'b1, 4'hF, 32'hFEE0001C, 32'hDEADBEEF, 8'h16, 1'b1, 1'b0, 32'h0,        8'h80};
        vt[7]  = '{1'b0, 4'h9, 32'hFEE0001C, 32'h0,        8'h17, 1'b1, 1'b0, 32'hDE0000EF, 8'h00};
        vt[8]  = '{1'b1, 4'h0, 32'hFEE00000, 32'hFFFFFFFF, 8'h18, 1'b1, 1'b0, 32'h0,        8'h01};
        vt[9]  = '{1'b0, 4'hF, 32'hFEE00000, 32'h0,        8'h19, 1'b1, 1'b0, 32'h0,        8'h00};
        vt[10] = '{1'b0, 4'hF, 32'hFEE000FC, 32'h0,        8'h1A, 1'b0, 1'b1, 32'h0,        8'h00};
        vt[11] = '{1'b1, 4'h2, 32'hFEE00018, 32'h12345678, 8'h1B, 1'b1, 1'b0, 32'h0,        8'h40};
        vt[12] = '{1'b0, 4'hF, 32'hFEE00018, 32'h0,        8'h1C, 1'b1, 1'b0, 32'h00005600, 8'h00};
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0;

        // Reset state
        rst  = 1'b1;
        req1 = '0;
        req0 = '0;
        step(2);
        @(negedge clk);
        check("rst_q_lo", q1[63:0], 64'h0);
        check("rst_resp_ctrl", {43'b0, resp1.ack, resp1.err, resp1.rty, resp1.stall, resp1.next,
                                resp1.pri, resp1.tid, wr1}, 64'h0);
        check("rst_resp_adr_dat", {resp1.adr, resp1.dat}, 64'h0);
        step(1);
        rst = 1'b0;
        step(2);

        // Table vectors
        for (int i = 0; i < 13; i++) txn(vt[i]);
        for (int i = 0; i < 8; i++) check("q_model", 64'(q1[32*i +: 32]), 64'(mregs[i]));

        // Back-to-back: second request held under stall, accepted once IDLE
        begin
            int c0;
            sb_t a, b;
            c0 = cyc;
            a = '{c0 + 2, 1'b1, 1'b0, 8'h09, 32'hFEE0001C, 32'hDEADBEEF, 8'h00};
            sbq.push_back(a);
            req1 = '{cyc: 1'b1, we: 1'b0, sel: 4'hF, adr: 32'hFEE0001C, dat: 32'h0, tid: 8'h09};
            step(1);
            b = '{c0 + 5, 1'b1, 1'b0, 8'h06, 32'hFEE00008, 32'h0, 8'h04};
            sbq.push_back(b);
            req1 = '{cyc: 1'b1, we: 1'b1, sel: 4'hF, adr: 32'hFEE00008, dat: 32'h0BADF00D, tid: 8'h06};
            @(negedge clk);
            check("b2b_stall_c1", 64'(resp1.stall), 64'h1);
            step(1);
            @(negedge clk);
            check("b2b_stall_c2", 64'(resp1.stall), 64'h1);
            step(1);
            @(negedge clk);
            check("b2b_stall_c3", 64'(resp1.stall), 64'h0);
            step(1);
            req1 = '0;
            step(3);
            mregs[2] = 32'h0BADF00D;
            check("b2b_reg2", 64'(q1[95:64]), 64'h0BADF00D);
        end

        // Window miss held for five cycles
        req1 = '{cyc: 1'b1, we: 1'b1, sel: 4'hF, adr: 32'hFEF00000, dat: 32'hFFFFFFFF, tid: 8'h77};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("miss_stall", 64'(resp1.stall), 64'h0);
            step(1);
        end
        req1 = '0;
        step(2);
        for (int i = 0; i < 8; i++) check("miss_q", 64'(q1[32*i +: 32]), 64'(mregs[i]));

        // Reset during the WAIT cycle of a write aborts it
        req1 = '{cyc: 1'b1, we: 1'b1, sel: 4'hF, adr: 32'hFEE0000C, dat: 32'h55555555, tid: 8'h33};
        step(1);
        req1 = '0;
        #2 rst = 1'b1;
        @(negedge clk);
        check("rst_mid_resp", {56'b0, resp1.ack, resp1.err, resp1.stall, 1'b0, resp1.pri}, 64'h0);
        step(1);
        rst = 1'b0;
        step(4);
        for (int i = 0; i < 8; i++) check("rst_mid_q", 64'(q1[32*i +: 32]), 64'h0);
        for (int i = 0; i < 8; i++) mregs[i] = 32'h0;

        // Write immediately followed by a read of the same register
        txn('{1'b1, 4'hF, 32'hFEE00004, 32'hCAFEF00D, 8'h41, 1'b1, 1'b0, 32'h0,        8'h02});
        txn('{1'b0, 4'hF, 32'hFEE00004, 32'h0,        8'h42, 1'b1, 1'b0, 32'hCAFEF00D, 8'h00});

        // Zero wait states: ack one cycle after the request
        req0 = '{cyc: 1'b1, we: 1'b1, sel: 4'h3, adr: 32'hFEE00014, dat: 32'h11223344, tid: 8'h50};
        step(1);
        req0 = '0;
        @(negedge clk);
        check("ws0_wr_ack", {46'b0, resp0.ack, resp0.err, resp0.tid, wr0}, {46'b0, 2'b10, 8'h50, 8'h20});
        step(1);
        @(negedge clk);
        check("ws0_after", {54'b0, resp0.ack, resp0.err, resp0.tid}, 64'h0);
        req0 = '{cyc: 1'b1, we: 1'b0, sel: 4'hF, adr: 32'hFEE00014, dat: 32'h0, tid: 8'h51};
        step(1);
        req0 = '0;
        @(negedge clk);
        check("ws0_rd", {30'b0, resp0.ack, resp0.err, resp0.dat}, {30'b0, 2'b10, 32'h00003344});
        check("ws0_q5", 64'(q0[191:160]), 64'h00003344);
        step(2);

        check("sb_drained", 64'(sbq.size()), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
